// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR / trap sequencer.
//   - request op codes and CSR index encoding (decoder encoding)
//   - FSM state type
//   - mstatus field positions and the ecall cause code
package csr_pkg;

    localparam logic [2:0] OP_CSRRW = 3'd0;
    localparam logic [2:0] OP_CSRRS = 3'd1;
    localparam logic [2:0] OP_ECALL = 3'd2;
    localparam logic [2:0] OP_MRET  = 3'd3;

    localparam logic [1:0] CSR_MSTATUS = 2'd0;
    localparam logic [1:0] CSR_MTVEC   = 2'd1;
    localparam logic [1:0] CSR_MEPC    = 2'd2;
    localparam logic [1:0] CSR_MCAUSE  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSR,
        ST_EPC,
        ST_CAUSE,
        ST_MRET,
        ST_RESP
    } state_t;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam int unsigned CAUSE_ECALL_M = 11;

    // Only CSRRW/CSRRS touch the addressed CSR; reserved ops are no-ops.
    function automatic logic is_csr_op(input logic [2:0] op);
        return (op == OP_CSRRW) || (op == OP_CSRRS);
    endfunction

endpackage

// File: rtl/csr_regfile.sv
// Machine-mode CSR storage: mstatus, mtvec, mepc, mcause.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_rd_idx/o_rd_data  combinational read port
//   i_we/i_wr_idx/i_wr_data  write port, WARL masks applied here
//   i_trap_enter      ecall entry: mcause <= 11, MPIE <= MIE, MIE <= 0
//   i_trap_ret        mret: MIE <= MPIE, MPIE <= 1
module csr_regfile
    import csr_pkg::*;
#(
    parameter int unsigned      XLEN        = 64,
    parameter logic [XLEN-1:0]  MSTATUS_RST = 64'h0000_000a_0000_1800
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      i_rd_idx,
    output logic [XLEN-1:0] o_rd_data,
    input  logic            i_we,
    input  logic [1:0]      i_wr_idx,
    input  logic [XLEN-1:0] i_wr_data,
    input  logic            i_trap_enter,
    input  logic            i_trap_ret
);

    logic [XLEN-1:0] r_mstatus;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;

    logic [XLEN-1:0] w_mstatus_wr;
    logic [XLEN-1:0] w_mstatus_trap;
    logic [XLEN-1:0] w_aligned_wr;

    always_comb begin
        o_rd_data = '0;
        case (i_rd_idx)
            CSR_MSTATUS: o_rd_data = r_mstatus;
            CSR_MTVEC:   o_rd_data = r_mtvec;
            CSR_MEPC:    o_rd_data = r_mepc;
            CSR_MCAUSE:  o_rd_data = r_mcause;
            default:     o_rd_data = '0;
        endcase
    end

    // WARL: MPP is hard-wired to M; mtvec/mepc are word aligned (direct mode).
    always_comb begin
        w_mstatus_wr = i_wr_data;
        w_mstatus_wr[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        w_aligned_wr = {i_wr_data[XLEN-1:2], 2'b00};
    end

    always_comb begin
        w_mstatus_trap = r_mstatus;
        if (i_trap_enter) begin
            w_mstatus_trap[MSTATUS_MPIE] = r_mstatus[MSTATUS_MIE];
            w_mstatus_trap[MSTATUS_MIE]  = 1'b0;
        end else if (i_trap_ret) begin
            w_mstatus_trap[MSTATUS_MIE]  = r_mstatus[MSTATUS_MPIE];
            w_mstatus_trap[MSTATUS_MPIE] = 1'b1;
        end
        w_mstatus_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mstatus <= MSTATUS_RST;
            r_mtvec   <= '0;
            r_mepc    <= '0;
            r_mcause  <= '0;
        end else begin
            if (i_trap_enter || i_trap_ret) begin
                r_mstatus <= w_mstatus_trap;
            end
            if (i_trap_enter) begin
                r_mcause <= XLEN'(CAUSE_ECALL_M);
            end
            if (i_we) begin
                case (i_wr_idx)
                    CSR_MSTATUS: r_mstatus <= w_mstatus_wr;
                    CSR_MTVEC:   r_mtvec   <= w_aligned_wr;
                    CSR_MEPC:    r_mepc    <= w_aligned_wr;
                    CSR_MCAUSE:  r_mcause  <= i_wr_data;
                    default:     ;
                endcase
            end
        end
    end

endmodule

// File: rtl/csr_trap_ctrl.sv
// Multi-cycle sequencer for M-mode CSR access, ecall and mret.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op, req_csr            op code and CSR index (csr_pkg encodings)
//   req_wdata, req_pc          rs1 value and instruction PC
//   rsp_valid                  one-cycle completion pulse
//   rsp_rdata                  old CSR value for CSR ops, else 0
//   rsp_redirect, rsp_target   fetch redirect for ecall/mret
module csr_trap_ctrl
    import csr_pkg::*;
#(
    parameter int unsigned      XLEN        = 64,
    parameter logic [XLEN-1:0]  MSTATUS_RST = 64'h0000_000a_0000_1800
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [1:0]      req_csr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [XLEN-1:0] req_pc,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_redirect,
    output logic [XLEN-1:0] rsp_target
);

    state_t          r_state;
    state_t          w_next;
    logic [2:0]      r_op;
    logic [1:0]      r_csr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] r_target;

    logic            w_accept;
    logic [1:0]      w_rd_idx;
    logic [XLEN-1:0] w_rd_data;
    logic            w_we;
    logic [1:0]      w_wr_idx;
    logic [XLEN-1:0] w_wr_data;
    logic            w_trap_enter;
    logic            w_trap_ret;

    csr_regfile #(
        .XLEN        (XLEN),
        .MSTATUS_RST (MSTATUS_RST)
    ) u_regfile (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_rd_idx     (w_rd_idx),
        .o_rd_data    (w_rd_data),
        .i_we         (w_we),
        .i_wr_idx     (w_wr_idx),
        .i_wr_data    (w_wr_data),
        .i_trap_enter (w_trap_enter),
        .i_trap_ret   (w_trap_ret)
    );

    assign w_accept = req_valid && req_ready;

    always_comb begin
        w_next       = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        rsp_redirect = 1'b0;
        w_rd_idx     = r_csr;
        w_we         = 1'b0;
        w_wr_idx     = r_csr;
        w_wr_data    = r_wdata;
        w_trap_enter = 1'b0;
        w_trap_ret   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    case (req_op)
                        OP_ECALL: w_next = ST_EPC;
                        OP_MRET:  w_next = ST_MRET;
                        default:  w_next = ST_CSR;
                    endcase
                end
            end
            ST_CSR: begin
                if (is_csr_op(r_op)) begin
                    w_we      = 1'b1;
                    w_wr_data = (r_op == OP_CSRRS) ? (w_rd_data | r_wdata) : r_wdata;
                end
                w_next = ST_RESP;
            end
            ST_EPC: begin
                // The mepc WARL mask drops pc[1:0], so the full PC is written.
                w_we      = 1'b1;
                w_wr_idx  = CSR_MEPC;
                w_wr_data = r_pc;
                w_next    = ST_CAUSE;
            end
            ST_CAUSE: begin
                w_trap_enter = 1'b1;
                w_rd_idx     = CSR_MTVEC;
                w_next       = ST_RESP;
            end
            ST_MRET: begin
                w_trap_ret = 1'b1;
                w_rd_idx   = CSR_MEPC;
                w_next     = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid    = 1'b1;
                rsp_redirect = (r_op == OP_ECALL) || (r_op == OP_MRET);
                w_next       = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Response registers are cleared on accept so fields that do not apply
    // to the op read as 0 during RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_csr    <= '0;
            r_wdata  <= '0;
            r_pc     <= '0;
            r_rdata  <= '0;
            r_target <= '0;
        end else begin
            if (w_accept) begin
                r_op     <= req_op;
                r_csr    <= req_csr;
                r_wdata  <= req_wdata;
                r_pc     <= req_pc;
                r_rdata  <= '0;
                r_target <= '0;
            end
            case (r_state)
                ST_CSR: begin
                    if (is_csr_op(r_op)) begin
                        r_rdata <= w_rd_data;
                    end
                end
                ST_CAUSE, ST_MRET: r_target <= w_rd_data;
                default: ;
            endcase
        end
    end

    assign rsp_rdata  = r_rdata;
    assign rsp_target = r_target;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;
    import csr_pkg::*;

    localparam logic [63:0] MS_RST = 64'h0000_000a_0000_1800;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [1:0]  req_csr = '0;
    logic [63:0] req_wdata = '0;
    logic [63:0] req_pc = '0;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_redirect;
    logic [63:0] rsp_target;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    typedef struct {
        logic [2:0]  op;
        logic [1:0]  csr;
        logic [63:0] wdata;
        logic [63:0] pc;
        int unsigned lat;
        logic [63:0] rdata;
        logic        redir;
        logic [63:0] target;
    } vec_t;

    vec_t tbl[$];
    vec_t post_rst[$];

    csr_trap_ctrl #(
        .XLEN        (64),
        .MSTATUS_RST (MS_RST)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_csr      (req_csr),
        .req_wdata    (req_wdata),
        .req_pc       (req_pc),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_redirect (rsp_redirect),
        .rsp_target   (rsp_target)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] op, input logic [1:0] csr,
                                input logic [63:0] wdata, input logic [63:0] pc,
                                input int unsigned lat, input logic [63:0] rdata,
                                input logic redir, input logic [63:0] target);
        vec_t v;
        v.op = op; v.csr = csr; v.wdata = wdata; v.pc = pc;
        v.lat = lat; v.rdata = rdata; v.redir = redir; v.target = target;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered and left on a falling edge with the DUT idle.
    task automatic apply_vec(input vec_t v, input string tag);
        int unsigned cyc;
        logic got;
        chk({tag, ".ready"}, 64'(req_ready), 64'd1);
        req_op = v.op; req_csr = v.csr; req_wdata = v.wdata; req_pc = v.pc;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op = OP_MRET; req_csr = ~v.csr; req_wdata = ONES; req_pc = ONES;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) got = 1'b1;
            else chk({tag, ".busy_ready"}, 64'(req_ready), 64'd0);
        end
        chk({tag, ".latency"}, 64'(cyc), 64'(v.lat));
        chk({tag, ".rdata"}, rsp_rdata, v.rdata);
        chk({tag, ".redirect"}, 64'(rsp_redirect), 64'(v.redir));
        chk({tag, ".target"}, rsp_target, v.target);
        @(negedge clk);
        chk({tag, ".pulse"}, 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // Main table, applied from reset.
        tbl.push_back(mk(OP_CSRRW, CSR_MTVEC,   64'h8000_0103, 0, 2, 64'h0, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MTVEC,   64'h0, 0, 2, 64'h8000_0100, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MSTATUS, 64'h8, 0, 2, MS_RST, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MSTATUS, 64'h0, 0, 2, 64'h0000_000a_0000_1808, 0, 0));
        tbl.push_back(mk(OP_ECALL, CSR_MSTATUS, 64'h0, 64'h8000_0040, 3, 64'h0, 1, 64'h8000_0100));
        tbl.push_back(mk(OP_CSRRS, CSR_MEPC,    64'h0, 0, 2, 64'h8000_0040, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MCAUSE,  64'h0, 0, 2, 64'd11, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MSTATUS, 64'h0, 0, 2, 64'h0000_000a_0000_1880, 0, 0));
        tbl.push_back(mk(OP_MRET,  CSR_MSTATUS, 64'h0, 64'h1234, 2, 64'h0, 1, 64'h8000_0040));
        tbl.push_back(mk(OP_CSRRS, CSR_MSTATUS, 64'h0, 0, 2, 64'h0000_000a_0000_1888, 0, 0));
        tbl.push_back(mk(OP_ECALL, CSR_MTVEC,   64'h0, 64'h8000_0046, 3, 64'h0, 1, 64'h8000_0100));
        tbl.push_back(mk(OP_MRET,  CSR_MTVEC,   64'h0, 64'h0, 2, 64'h0, 1, 64'h8000_0044));
        tbl.push_back(mk(OP_CSRRS, CSR_MSTATUS, 64'h0, 0, 2, 64'h0000_000a_0000_1888, 0, 0));
        tbl.push_back(mk(OP_CSRRW, CSR_MEPC,    64'h1234_5677, 0, 2, 64'h8000_0044, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MEPC,    64'h0, 0, 2, 64'h1234_5674, 0, 0));
        tbl.push_back(mk(OP_CSRRW, CSR_MSTATUS, 64'h0, 0, 2, 64'h0000_000a_0000_1888, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MSTATUS, 64'h0, 0, 2, 64'h0000_0000_0000_1800, 0, 0));
        tbl.push_back(mk(OP_CSRRW, CSR_MCAUSE,  ONES, 0, 2, 64'd11, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MCAUSE,  64'h0, 0, 2, ONES, 0, 0));
        tbl.push_back(mk(3'd5,     CSR_MCAUSE,  64'h55, 0, 2, 64'h0, 0, 0));
        tbl.push_back(mk(3'd7,     CSR_MTVEC,   64'h0, 0, 2, 64'h0, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MCAUSE,  64'h0, 0, 2, ONES, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MTVEC,   64'h0, 0, 2, 64'h8000_0100, 0, 0));
        tbl.push_back(mk(OP_MRET,  CSR_MEPC,    64'h0, 0, 2, 64'h0, 1, 64'h1234_5674));
        tbl.push_back(mk(OP_CSRRS, CSR_MSTATUS, 64'h0, 0, 2, 64'h0000_0000_0000_1880, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MTVEC,   64'h3, 0, 2, 64'h8000_0100, 0, 0));
        tbl.push_back(mk(OP_CSRRS, CSR_MTVEC,   64'h0, 0, 2, 64'h8000_0100, 0, 0));

        // Read-back of every CSR after a reset abandoned an ecall.
        post_rst.push_back(mk(OP_CSRRS, CSR_MSTATUS, 64'h0, 0, 2, MS_RST, 0, 0));
        post_rst.push_back(mk(OP_CSRRS, CSR_MTVEC,   64'h0, 0, 2, 64'h0, 0, 0));
        post_rst.push_back(mk(OP_CSRRS, CSR_MEPC,    64'h0, 0, 2, 64'h0, 0, 0));
        post_rst.push_back(mk(OP_CSRRS, CSR_MCAUSE,  64'h0, 0, 2, 64'h0, 0, 0));

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst.ready",    64'(req_ready),    64'd1);
        chk("rst.valid",    64'(rsp_valid),    64'd0);
        chk("rst.redirect", 64'(rsp_redirect), 64'd0);
        chk("rst.rdata",    rsp_rdata,         64'd0);
        chk("rst.target",   rsp_target,        64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tbl[i]) apply_vec(tbl[i], $sformatf("vec%0d", i));

        // req_valid held high: accepts every third cycle.
        req_op = OP_CSRRS; req_csr = CSR_MCAUSE; req_wdata = '0; req_pc = '0;
        req_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("hold%0d.ready", i), 64'(req_ready), 64'((i % 3) == 0));
            chk($sformatf("hold%0d.valid", i), 64'(rsp_valid), 64'((i % 3) == 2));
            if ((i % 3) == 2) chk($sformatf("hold%0d.rdata", i), rsp_rdata, ONES);
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("hold.end_ready", 64'(req_ready), 64'd1);

        // Set MIE and a trap vector, then reset during the CAUSE cycle.
        apply_vec(mk(OP_CSRRS, CSR_MSTATUS, 64'h8, 0, 2, 64'h0000_0000_0000_1880, 0, 0), "pre0");
        apply_vec(mk(OP_CSRRW, CSR_MTVEC, 64'h4000_0000, 0, 2, 64'h8000_0100, 0, 0), "pre1");
        req_op = OP_ECALL; req_pc = 64'h8000_0080; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort.epc_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("abort.cause_valid", 64'(rsp_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("abort.ready",  64'(req_ready),  64'd1);
        chk("abort.target", rsp_target,      64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort%0d.valid", i), 64'(rsp_valid), 64'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort.idle_valid", 64'(rsp_valid), 64'd0);
        foreach (post_rst[i]) apply_vec(post_rst[i], $sformatf("post%0d", i));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
